// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared widths and types for the processor memory path
//
// Purpose: common definitions used by the instruction/data memory arbiter.
//   WORD_SIZE    data and address width of the unified RAM
//   arb_state_t  access sequencer states IDLE -> ISSUE -> WAIT -> RESP
//   arb_port_t   identifies the requester that owns the current access
package proc_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } arb_port_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - grant select between instruction fetch and data port
//
// Purpose: combinational choice of which port owns the next memory access.
//   Data wins a tie because it sits deeper in the pipeline. When the macro
//   ARB_FAIRNESS_EN is defined, a saturating starvation counter forces an
//   instruction grant after STARVE_LIMIT consecutive data grants made while
//   a fetch was waiting. Without the macro the counter is not built.
// Ports:
//   Clock, Reset  clock (rising edge), asynchronous active-high reset
//   instr_req     fetch request pending
//   data_req      data request pending
//   take          the sequencer accepts the grant this cycle
//   grant         port selected for the next access
module mem_arb_pick
  import proc_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      Clock,
  input  logic      Reset,
  input  logic      instr_req,
  input  logic      data_req,
  input  logic      take,
  output arb_port_t grant
);

`ifdef ARB_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q;
  logic          force_instr;

  assign force_instr = (starve_q == LIMIT);

  always_comb begin
    grant = PORT_DATA;
    if (instr_req && (!data_req || force_instr)) begin
      grant = PORT_INSTR;
    end
  end

  // Only data grants that actually bypass a waiting fetch count as starvation.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      starve_q <= '0;
    end else if (take) begin
      if (grant == PORT_INSTR) begin
        starve_q <= '0;
      end else if (instr_req && !force_instr) begin
        starve_q <= starve_q + SW'(1);
      end
    end
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;

  logic unused_pick;
  assign unused_pick = &{1'b0, Clock, Reset, take};

  always_comb begin
    grant = PORT_DATA;
    if (instr_req && !data_req) begin
      grant = PORT_INSTR;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port synchronous RAM between fetch and data ports
//
// Purpose: sequences each access through IDLE -> ISSUE -> WAIT -> RESP and
//   returns a one-cycle done pulse to the granted requester. Requests are
//   sampled only in IDLE. Optional fairness is enabled with ARB_FAIRNESS_EN.
// Ports:
//   Clock, Reset                 clock (rising edge), async active-high reset
//   instr_req/instr_addr         fetch request (level, held until instr_done)
//   instr_rdata/instr_done       fetched word, valid with the done pulse
//   data_req/data_we/data_addr/data_wdata  load/store request
//   data_rdata/data_done         load data, valid with the done pulse
//   mem_addr/mem_wdata/mem_we/mem_re       RAM command, driven only in ISSUE
//   mem_rdata                    RAM read data, MEM_LATENCY cycles after mem_re
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 instr_req,
  input  logic [WORD_SIZE-1:0] instr_addr,
  output logic [WORD_SIZE-1:0] instr_rdata,
  output logic                 instr_done,
  input  logic                 data_req,
  input  logic                 data_we,
  input  logic [WORD_SIZE-1:0] data_addr,
  input  logic [WORD_SIZE-1:0] data_wdata,
  output logic [WORD_SIZE-1:0] data_rdata,
  output logic                 data_done,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_t           state_q;
  arb_port_t            grant_q;
  logic                 we_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WORD_SIZE-1:0] mem_addr_q;
  logic [WORD_SIZE-1:0] mem_wdata_q;
  logic                 mem_we_q;
  logic                 mem_re_q;
  logic [WORD_SIZE-1:0] instr_rdata_q;
  logic [WORD_SIZE-1:0] data_rdata_q;
  logic                 instr_done_q;
  logic                 data_done_q;

  logic      take;
  arb_port_t pick_grant;

  assign take = (state_q == IDLE) && (instr_req || data_req);

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .Clock    (Clock),
    .Reset    (Reset),
    .instr_req(instr_req),
    .data_req (data_req),
    .take     (take),
    .grant    (pick_grant)
  );

  // mem_* and done are registered: they are loaded on the edge that enters
  // ISSUE / RESP and fall back to zero on every other edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      grant_q       <= PORT_INSTR;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
      instr_done_q  <= 1'b0;
      data_done_q   <= 1'b0;
    end else begin
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      instr_done_q <= 1'b0;
      data_done_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (take) begin
            grant_q <= pick_grant;
            if (pick_grant == PORT_DATA) begin
              we_q        <= data_we;
              mem_addr_q  <= data_addr;
              mem_wdata_q <= data_we ? data_wdata : '0;
              mem_we_q    <= data_we;
              mem_re_q    <= !data_we;
            end else begin
              we_q       <= 1'b0;
              mem_addr_q <= instr_addr;
              mem_re_q   <= 1'b1;
            end
            state_q <= ISSUE;
          end
        end

        ISSUE: begin
          if (we_q) begin
            // Stores complete without waiting for the RAM.
            if (grant_q == PORT_DATA) begin
              data_done_q <= 1'b1;
            end else begin
              instr_done_q <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            cnt_q   <= LAT_LOAD;
            state_q <= WAIT;
          end
        end

        WAIT: begin
          // WAIT lasts MEM_LATENCY cycles; read data is valid in the last one.
          if (cnt_q == '0) begin
            if (grant_q == PORT_DATA) begin
              data_rdata_q <= mem_rdata;
              data_done_q  <= 1'b1;
            end else begin
              instr_rdata_q <= mem_rdata;
              instr_done_q  <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        RESP: begin
          we_q    <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;
  assign instr_rdata = instr_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign instr_done  = instr_done_q;
  assign data_done   = data_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic Clock;
  logic Reset;

  logic        i1_req, i1_done, d1_req, d1_we, d1_done, m1_we, m1_re;
  logic [15:0] i1_addr, i1_rdata, d1_addr, d1_wdata, d1_rdata;
  logic [15:0] m1_addr, m1_wdata, m1_rdata;

  logic        i4_req, i4_done, d4_req, d4_we, d4_done, m4_we, m4_re;
  logic [15:0] i4_addr, i4_rdata, d4_addr, d4_wdata, d4_rdata;
  logic [15:0] m4_addr, m4_wdata, m4_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_l1 (
    .Clock(Clock), .Reset(Reset),
    .instr_req(i1_req), .instr_addr(i1_addr), .instr_rdata(i1_rdata), .instr_done(i1_done),
    .data_req(d1_req), .data_we(d1_we), .data_addr(d1_addr), .data_wdata(d1_wdata),
    .data_rdata(d1_rdata), .data_done(d1_done),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_we(m1_we), .mem_re(m1_re),
    .mem_rdata(m1_rdata)
  );

  mem_port_arbiter #(.MEM_LATENCY(4), .STARVE_LIMIT(4)) u_l4 (
    .Clock(Clock), .Reset(Reset),
    .instr_req(i4_req), .instr_addr(i4_addr), .instr_rdata(i4_rdata), .instr_done(i4_done),
    .data_req(d4_req), .data_we(d4_we), .data_addr(d4_addr), .data_wdata(d4_wdata),
    .data_rdata(d4_rdata), .data_done(d4_done),
    .mem_addr(m4_addr), .mem_wdata(m4_wdata), .mem_we(m4_we), .mem_re(m4_re),
    .mem_rdata(m4_rdata)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory models: fixed contents at 0x10/0x20/0x30/0x50, writable overlay.
  function automatic logic [15:0] rom(input logic [3:0] idx);
    case (idx)
      4'h1:    rom = 16'hBEEF;
      4'h2:    rom = 16'hCAFE;
      4'h3:    rom = 16'h5A5A;
      4'h5:    rom = 16'h7777;
      default: rom = 16'h0000;
    endcase
  endfunction

  logic [15:0] wm1 [0:15];
  logic [15:0] wv1;
  logic [15:0] wm4 [0:15];
  logic [15:0] wv4;
  logic [15:0] pipe4 [0:3];

  wire unused_tb = ^{m1_addr, m4_addr, i4_rdata, i4_done};

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wv1      <= '0;
      m1_rdata <= '0;
    end else begin
      if (m1_we) begin
        wm1[m1_addr[7:4]] <= m1_wdata;
        wv1[m1_addr[7:4]] <= 1'b1;
      end
      m1_rdata <= m1_re ? (wv1[m1_addr[7:4]] ? wm1[m1_addr[7:4]] : rom(m1_addr[7:4])) : 16'h0;
    end
  end

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wv4 <= '0;
      for (int k = 0; k < 4; k++) pipe4[k] <= '0;
    end else begin
      if (m4_we) begin
        wm4[m4_addr[7:4]] <= m4_wdata;
        wv4[m4_addr[7:4]] <= 1'b1;
      end
      pipe4[0] <= m4_re ? (wv4[m4_addr[7:4]] ? wm4[m4_addr[7:4]] : rom(m4_addr[7:4])) : 16'h0;
      for (int k = 1; k < 4; k++) pipe4[k] <= pipe4[k-1];
    end
  end
  assign m4_rdata = pipe4[3];

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int   cyc;
  int   n_done;
  int   t_done [0:2];
  logic exp_instr;
  logic seen;

  initial begin
    Reset = 1'b1;
    i1_req = 0; i1_addr = 0; d1_req = 0; d1_we = 0; d1_addr = 0; d1_wdata = 0;
    i4_req = 0; i4_addr = 0; d4_req = 0; d4_we = 0; d4_addr = 0; d4_wdata = 0;
    tick(); tick();

    // Reset state
    chk1 ("rst_m1_re",    m1_re,    1'b0);
    chk1 ("rst_m1_we",    m1_we,    1'b0);
    chk16("rst_m1_addr",  m1_addr,  16'h0000);
    chk1 ("rst_i1_done",  i1_done,  1'b0);
    chk1 ("rst_d1_done",  d1_done,  1'b0);
    chk16("rst_i1_rdata", i1_rdata, 16'h0000);
    chk1 ("rst_m4_re",    m4_re,    1'b0);
    chk16("rst_d4_rdata", d4_rdata, 16'h0000);
    Reset = 1'b0;
    tick();

    // Lone fetch, latency 1: mem_re at cycle 1, done at cycle 3
    i1_req = 1; i1_addr = 16'h0010;
    tick();
    chk1 ("t2_re_c1",   m1_re,   1'b1);
    chk16("t2_addr_c1", m1_addr, 16'h0010);
    chk1 ("t2_done_c1", i1_done, 1'b0);
    tick();
    chk1 ("t2_re_c2",   m1_re,   1'b0);
    chk1 ("t2_done_c2", i1_done, 1'b0);
    tick();
    chk1 ("t2_done_c3", i1_done,  1'b1);
    chk16("t2_rdata",   i1_rdata, 16'hBEEF);
    chk1 ("t2_ddone",   d1_done,  1'b0);
    i1_req = 0;
    tick();
    chk1 ("t2_done_c4", i1_done,  1'b0);
    chk16("t2_hold",    i1_rdata, 16'hBEEF);

    // Store 0x1234 to 0x0040, then read it back
    d1_req = 1; d1_we = 1; d1_addr = 16'h0040; d1_wdata = 16'h1234;
    tick();
    chk1 ("t3_we_c1",    m1_we,    1'b1);
    chk1 ("t3_re_c1",    m1_re,    1'b0);
    chk16("t3_addr_c1",  m1_addr,  16'h0040);
    chk16("t3_wdata_c1", m1_wdata, 16'h1234);
    tick();
    chk1 ("t3_we_c2",    m1_we,    1'b0);
    chk1 ("t3_done_c2",  d1_done,  1'b1);
    d1_req = 0; d1_we = 0; d1_wdata = 0;
    tick();
    chk1 ("t3_done_c3",  d1_done,  1'b0);
    d1_req = 1;
    tick();
    chk1 ("t3_rb_re",    m1_re,    1'b1);
    tick(); tick();
    chk1 ("t3_rb_done",  d1_done,  1'b1);
    chk16("t3_rb_data",  d1_rdata, 16'h1234);
    d1_req = 0;
    tick();

    // Simultaneous requests: data first, fetch after one IDLE cycle
    i1_req = 1; i1_addr = 16'h0020; d1_req = 1; d1_addr = 16'h0030;
    tick();
    chk16("t4_first_addr", m1_addr, 16'h0030);
    chk1 ("t4_first_re",   m1_re,   1'b1);
    tick(); tick();
    chk1 ("t4_ddone",      d1_done,  1'b1);
    chk1 ("t4_idone_c3",   i1_done,  1'b0);
    chk16("t4_drdata",     d1_rdata, 16'h5A5A);
    chk16("t4_ihold",      i1_rdata, 16'hBEEF);
    d1_req = 0;
    tick();
    chk1 ("t4_idle_re",    m1_re,   1'b0);
    tick();
    chk16("t4_second_addr", m1_addr, 16'h0020);
    chk1 ("t4_second_re",   m1_re,   1'b1);
    tick(); tick();
    chk1 ("t4_idone",      i1_done,  1'b1);
    chk1 ("t4_ddone_c7",   d1_done,  1'b0);
    chk16("t4_irdata",     i1_rdata, 16'hCAFE);
    i1_req = 0;
    tick();

    // Both requests held high: grant pattern over ten completions
    i1_req = 1; d1_req = 1;
    n_done = 0; cyc = 0;
    while (n_done < 10 && cyc < 100) begin
      tick();
      cyc++;
      if (i1_done || d1_done) begin
        chk1($sformatf("t5_excl%0d", n_done), i1_done & d1_done, 1'b0);
        exp_instr = 1'b0;
`ifdef ARB_FAIRNESS_EN
        exp_instr = ((n_done % 5) == 4);
`endif
        chk1($sformatf("t5_grant%0d", n_done), i1_done, exp_instr);
        n_done++;
        if (n_done == 10) begin
          i1_req = 0; d1_req = 0;
        end
      end
    end
    chk1("t5_budget", n_done == 10, 1'b1);
    i1_req = 0; d1_req = 0;
    tick();

    // Latency 4 back-to-back loads: done at cycle 6, then every 7 cycles
    d4_req = 1; d4_we = 0; d4_addr = 16'h0050;
    n_done = 0; cyc = 0;
    while (n_done < 3 && cyc < 80) begin
      tick();
      cyc++;
      if (d4_done) begin
        if (n_done == 0) chk16("t6_rdata", d4_rdata, 16'h7777);
        t_done[n_done] = cyc;
        n_done++;
        if (n_done == 3) d4_req = 0;
      end
    end
    d4_req = 0;
    chk1 ("t6_budget", n_done == 3, 1'b1);
    chk16("t6_first",  16'(t_done[0]), 16'd6);
    chk16("t6_gap1",   16'(t_done[1] - t_done[0]), 16'd7);
    chk16("t6_gap2",   16'(t_done[2] - t_done[1]), 16'd7);
    tick();

    // Reset during WAIT of a latency-4 load
    d4_req = 1; d4_we = 0; d4_addr = 16'h0050;
    tick();
    chk1("t1_re_c1", m4_re, 1'b1);
    tick(); tick();
    chk1("t1_wait_done", d4_done, 1'b0);
    Reset = 1'b1; d4_req = 0;
    #1;
    chk1 ("t1_rst_re",    m4_re,    1'b0);
    chk16("t1_rst_addr",  m4_addr,  16'h0000);
    chk16("t1_rst_rdata", d4_rdata, 16'h0000);
    chk1 ("t1_rst_done",  d4_done,  1'b0);
    tick();
    Reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (d4_done) seen = 1'b1;
    end
    chk1("t1_no_done", seen, 1'b0);
    d4_req = 1; d4_we = 1; d4_addr = 16'h0060; d4_wdata = 16'hA5A5;
    tick();
    chk1 ("t1_post_we",    m4_we,    1'b1);
    chk16("t1_post_wdata", m4_wdata, 16'hA5A5);
    tick();
    chk1 ("t1_post_done",  d4_done,  1'b1);
    d4_req = 0; d4_we = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
